// File: rtl/cluster_pkg.sv
// Shared widths, cluster word encoding and FSM state type for the cluster frame packer.
// Optional feature macro: CLUSTER_PARITY_EN (appends an even-parity LSB to every cluster).
package cluster_pkg;

  localparam int MXADRBITS = 11;
  localparam int MXCNTBITS = 3;
  localparam logic [MXADRBITS-1:0] INVALID_ADR = {MXADRBITS{1'b1}};

  localparam int NCLUSTERS = 8;
  localparam int NSLOTS    = 4;

  function automatic int cluster_width();
`ifdef CLUSTER_PARITY_EN
    return MXADRBITS + MXCNTBITS + 1;
`else
    return MXADRBITS + MXCNTBITS;
`endif
  endfunction

  localparam int CW = cluster_width();

  typedef logic [CW-1:0]   cluster_word_t;
  typedef logic [2*CW-1:0] pair_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Even parity: the appended bit makes the XOR over adr, cnt and parity zero.
  function automatic logic even_parity(input logic [MXADRBITS-1:0] adr,
                                       input logic [MXCNTBITS-1:0] cnt);
    return ^{adr, cnt};
  endfunction

  function automatic cluster_word_t pack_cluster(input logic [MXADRBITS-1:0] adr,
                                                 input logic [MXCNTBITS-1:0] cnt);
`ifdef CLUSTER_PARITY_EN
    return {adr, cnt, even_parity(adr, cnt)};
`else
    return {adr, cnt};
`endif
  endfunction

  localparam cluster_word_t INVALID_CLUSTER = pack_cluster(INVALID_ADR, {MXCNTBITS{1'b0}});
  localparam pair_word_t    INVALID_PAIR    = {INVALID_CLUSTER, INVALID_CLUSTER};

endpackage

// File: rtl/cluster_slot_mux.sv
// Picks the cluster pair {cluster 2k+1, cluster 2k} for slot k out of the captured frame.
module cluster_slot_mux
  import cluster_pkg::*;
(
  input  cluster_word_t cap [NCLUSTERS],
  input  logic [1:0]    slot,
  output pair_word_t    pair
);

  always_comb begin
    pair = {cap[1], cap[0]};
    case (slot)
      2'd0:    pair = {cap[1], cap[0]};
      2'd1:    pair = {cap[3], cap[2]};
      2'd2:    pair = {cap[5], cap[4]};
      2'd3:    pair = {cap[7], cap[6]};
      default: pair = {cap[1], cap[0]};
    endcase
  end

endmodule

// File: rtl/cluster_frame_packer.sv
// Captures 8 sorted clusters on mux_pulse_in and serializes them as 4 pair-words per BX frame.
// Build option: CLUSTER_PARITY_EN adds an even-parity bit to each cluster.
module cluster_frame_packer
  import cluster_pkg::*;
(
  input  logic                 clock4x,
  input  logic                 reset_n,
  input  logic                 mux_pulse_in,
  input  logic [MXADRBITS-1:0] adr_in0,
  input  logic [MXADRBITS-1:0] adr_in1,
  input  logic [MXADRBITS-1:0] adr_in2,
  input  logic [MXADRBITS-1:0] adr_in3,
  input  logic [MXADRBITS-1:0] adr_in4,
  input  logic [MXADRBITS-1:0] adr_in5,
  input  logic [MXADRBITS-1:0] adr_in6,
  input  logic [MXADRBITS-1:0] adr_in7,
  input  logic [MXCNTBITS-1:0] cnt_in0,
  input  logic [MXCNTBITS-1:0] cnt_in1,
  input  logic [MXCNTBITS-1:0] cnt_in2,
  input  logic [MXCNTBITS-1:0] cnt_in3,
  input  logic [MXCNTBITS-1:0] cnt_in4,
  input  logic [MXCNTBITS-1:0] cnt_in5,
  input  logic [MXCNTBITS-1:0] cnt_in6,
  input  logic [MXCNTBITS-1:0] cnt_in7,
  output pair_word_t           word_o,
  output logic                 word_valid_o,
  output logic                 frame_start_o,
  output logic [3:0]           nclusters_o,
  output logic                 sync_err_o,
  output state_e               dbg_state_o,
  output logic [1:0]           dbg_slot_o
);

  // Link-side handshake: word_valid_o qualifies word_o every cycle; there is no
  // ready/backpressure, so the receiver must accept each valid word as presented.

  logic [MXADRBITS-1:0] adr_in [NCLUSTERS];
  logic [MXCNTBITS-1:0] cnt_in [NCLUSTERS];
  cluster_word_t        in_word [NCLUSTERS];
  cluster_word_t        cap_q   [NCLUSTERS];
  logic [3:0]           in_count;

  assign adr_in = '{adr_in0, adr_in1, adr_in2, adr_in3, adr_in4, adr_in5, adr_in6, adr_in7};
  assign cnt_in = '{cnt_in0, cnt_in1, cnt_in2, cnt_in3, cnt_in4, cnt_in5, cnt_in6, cnt_in7};

  always_comb begin
    in_count = 4'd0;
    for (int i = 0; i < NCLUSTERS; i++) begin
      in_word[i] = pack_cluster(adr_in[i], cnt_in[i]);
      if (adr_in[i] != INVALID_ADR) in_count = in_count + 4'd1;
    end
  end

  state_e     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [1:0] slot_next;
  pair_word_t mux_pair;
  pair_word_t word_d;
  logic       valid_d, start_d, err_d;
  logic [3:0] ncl_d;
  logic       early_pulse;

  assign slot_next   = slot_q + 2'd1;
  assign early_pulse = mux_pulse_in && (state_q == ST_SEND) && (slot_q != 2'd3);

  // Slot 0 comes straight from the inputs on the pulse edge; slots 1..3 from the capture register.
  cluster_slot_mux u_slot_mux (
    .cap  (cap_q),
    .slot (slot_next),
    .pair (mux_pair)
  );

  always_comb begin
    state_d = ST_IDLE;
    slot_d  = 2'd0;
    word_d  = INVALID_PAIR;
    valid_d = 1'b0;
    start_d = 1'b0;
    ncl_d   = 4'd0;
    err_d   = sync_err_o | early_pulse;
    if (mux_pulse_in) begin
      state_d = ST_SEND;
      slot_d  = 2'd0;
      word_d  = {in_word[1], in_word[0]};
      valid_d = 1'b1;
      start_d = 1'b1;
      ncl_d   = in_count;
    end else if (state_q == ST_SEND && slot_q != 2'd3) begin
      state_d = ST_SEND;
      slot_d  = slot_next;
      word_d  = mux_pair;
      valid_d = 1'b1;
      ncl_d   = nclusters_o;
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      slot_q        <= 2'd0;
      word_o        <= INVALID_PAIR;
      word_valid_o  <= 1'b0;
      frame_start_o <= 1'b0;
      nclusters_o   <= 4'd0;
      sync_err_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      word_o        <= word_d;
      word_valid_o  <= valid_d;
      frame_start_o <= start_d;
      nclusters_o   <= ncl_d;
      sync_err_o    <= err_d;
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCLUSTERS; i++) cap_q[i] <= INVALID_CLUSTER;
    end else if (mux_pulse_in) begin
      for (int i = 0; i < NCLUSTERS; i++) cap_q[i] <= in_word[i];
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_slot_o  = slot_q;

endmodule
